// File: rtl/pipe_stall_ctrl_if.sv
// Hazard inputs and per-stage stall/flush controls exchanged between the
// pipeline datapath (master) and the central stall sequencer (slave).
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_ex_memRead;
    logic [4:0]       id_ex_regRt;
    logic [4:0]       if_id_regRs;
    logic [4:0]       if_id_regRt;
    logic             branch_taken;
    logic             md_start;
    logic             md_done;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             ctrl_mux;
    logic             md_go;
    logic             md_err;
    logic             md_busy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_ex_memRead, id_ex_regRt, if_id_regRs, if_id_regRt,
               branch_taken, md_start, md_done,
        input  pc_write, ifid_write, ifid_flush, ctrl_mux,
               md_go, md_err, md_busy, stall_cycles
    );

    modport slave (
        input  id_ex_memRead, id_ex_regRt, if_id_regRs, if_id_regRt,
               branch_taken, md_start, md_done,
        output pc_write, ifid_write, ifid_flush, ctrl_mux,
               md_go, md_err, md_busy, stall_cycles
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer: merges load-use, taken-branch and mul/div wait
// hazards into PC / IF-ID / ID-EX controls, with a saturating stall counter.
module pipe_stall_ctrl #(
    parameter int MD_MAX_CYCLES = 64,
    parameter int CNT_W         = 16
) (
    input logic             clk,
    input logic             reset,
    pipe_stall_ctrl_if.slave bus
);
    localparam int                WAIT_W    = 16;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_MAX_CYCLES - 1);

    typedef enum logic {RUN, MD_BUSY} state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [CNT_W-1:0]  stall_cnt;
    logic              lu;
    logic              pc_write, ifid_write, ifid_flush, ctrl_mux;
    logic              md_go, md_err, md_busy;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign lu = bus.id_ex_memRead && (bus.id_ex_regRt != 5'd0) &&
                ((bus.id_ex_regRt == bus.if_id_regRs) ||
                 (bus.id_ex_regRt == bus.if_id_regRt));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (!pc_write)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

    always_comb begin
        state_nxt  = state;
        wait_nxt   = wait_cnt;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
        ctrl_mux   = 1'b0;
        md_go      = 1'b0;
        md_err     = 1'b0;
        md_busy    = 1'b0;
        if (!reset) begin
            unique case (state)
                RUN: begin
                    if (bus.branch_taken) begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                        ifid_flush = 1'b1;
                    end else if (lu) begin
                        // one bubble; hold PC and IF/ID
                    end else if (bus.md_start) begin
                        md_go     = 1'b1;
                        ctrl_mux  = 1'b1;
                        wait_nxt  = '0;
                        state_nxt = MD_BUSY;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                        ctrl_mux   = 1'b1;
                    end
                end
                MD_BUSY: begin
                    md_busy  = 1'b1;
                    wait_nxt = wait_cnt + WAIT_W'(1);
                    // A done arriving on the timeout cycle wins over the abort.
                    if (bus.md_done || (wait_cnt == WAIT_LAST)) begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                        ctrl_mux   = 1'b1;
                        md_err     = !bus.md_done;
                        state_nxt  = RUN;
                    end
                end
            endcase
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.ifid_write   = ifid_write;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.ctrl_mux     = ctrl_mux;
    assign bus.md_go        = md_go;
    assign bus.md_err       = md_err;
    assign bus.md_busy      = md_busy;
    assign bus.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: vector table, hand-written corner sequences and
// random stimulus against a behavioural model (two counter widths in parallel).
module tb_pipe_stall_ctrl;
    localparam int MAXC = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_stall_ctrl_if #(.CNT_W(16)) bus_a ();
    pipe_stall_ctrl_if #(.CNT_W(4))  bus_b ();

    assign bus_b.id_ex_memRead = bus_a.id_ex_memRead;
    assign bus_b.id_ex_regRt   = bus_a.id_ex_regRt;
    assign bus_b.if_id_regRs   = bus_a.if_id_regRs;
    assign bus_b.if_id_regRt   = bus_a.if_id_regRt;
    assign bus_b.branch_taken  = bus_a.branch_taken;
    assign bus_b.md_start      = bus_a.md_start;
    assign bus_b.md_done       = bus_a.md_done;

    pipe_stall_ctrl #(.MD_MAX_CYCLES(MAXC), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave));
    pipe_stall_ctrl #(.MD_MAX_CYCLES(MAXC), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));

    typedef struct {
        logic       mr;
        logic [4:0] ex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic       ms;
        logic [4:0] exp_ctl;   // {pc_write, ifid_write, ifid_flush, ctrl_mux, md_go}
    } vec_t;

    vec_t vecs[10];
    int   n_vec = 0;
    int   n_err = 0;

    // Model state: whether a mul/div is outstanding, how many busy cycles have
    // completed, and the ideal stall counts for each counter width.
    bit m_busy;
    int m_len;
    int m_st16;
    int m_st4;

    task automatic set_in(input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                          input logic [4:0] rt, input logic br, input logic ms, input logic md);
        bus_a.id_ex_memRead = mr;
        bus_a.id_ex_regRt   = ex_rt;
        bus_a.if_id_regRs   = rs;
        bus_a.if_id_regRt   = rt;
        bus_a.branch_taken  = br;
        bus_a.md_start      = ms;
        bus_a.md_done       = md;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic sample();
        logic [6:0] e_ctl, a_ctl, b_ctl;
        logic       lu, rel;
        @(negedge clk);
        e_ctl = '0;
        rel   = 1'b0;
        lu = bus_a.id_ex_memRead && bus_a.id_ex_regRt != 0 &&
             (bus_a.id_ex_regRt == bus_a.if_id_regRs || bus_a.id_ex_regRt == bus_a.if_id_regRt);
        // e_ctl = {pc_write, ifid_write, ifid_flush, ctrl_mux, md_go, md_err, md_busy}
        if (!reset) begin
            if (!m_busy) begin
                if (bus_a.branch_taken)  e_ctl = 7'b1110000;
                else if (lu)             e_ctl = 7'b0000000;
                else if (bus_a.md_start) e_ctl = 7'b0001100;
                else                     e_ctl = 7'b1101000;
            end else begin
                rel = bus_a.md_done || (m_len + 1 == MAXC);
                if (rel) e_ctl = {4'b1101, 1'b0, !bus_a.md_done, 1'b1};
                else     e_ctl = 7'b0000001;
            end
        end
        a_ctl = {bus_a.pc_write, bus_a.ifid_write, bus_a.ifid_flush, bus_a.ctrl_mux,
                 bus_a.md_go, bus_a.md_err, bus_a.md_busy};
        b_ctl = {bus_b.pc_write, bus_b.ifid_write, bus_b.ifid_flush, bus_b.ctrl_mux,
                 bus_b.md_go, bus_b.md_err, bus_b.md_busy};
        n_vec++;
        if (a_ctl !== e_ctl || b_ctl !== e_ctl || bus_a.stall_cycles !== 16'(m_st16) ||
            bus_b.stall_cycles !== 4'(m_st4)) begin
            n_err++;
            $display("FAIL model at %0t: got ctl=%b/%b cnt=%0d/%0d, expected ctl=%b cnt=%0d/%0d",
                     $time, a_ctl, b_ctl, bus_a.stall_cycles, bus_b.stall_cycles,
                     e_ctl, m_st16, m_st4);
        end
        if (reset) begin
            m_busy = 0; m_len = 0; m_st16 = 0; m_st4 = 0;
        end else begin
            if (!e_ctl[6]) begin
                m_st16 = (m_st16 < 65535) ? m_st16 + 1 : m_st16;
                m_st4  = (m_st4 < 15) ? m_st4 + 1 : m_st4;
            end
            if (!m_busy) begin
                if (!bus_a.branch_taken && !lu && bus_a.md_start) begin
                    m_busy = 1; m_len = 0;
                end
            end else if (rel) begin
                m_busy = 0;
            end else begin
                m_len++;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (n) cycle();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1, 5'd5,  5'd5,  5'd0,  0, 0, 5'b00000};
        vecs[1] = '{1, 5'd0,  5'd0,  5'd0,  0, 0, 5'b11010};
        vecs[2] = '{1, 5'd7,  5'd3,  5'd4,  0, 0, 5'b11010};
        vecs[3] = '{0, 5'd9,  5'd9,  5'd9,  0, 0, 5'b11010};
        vecs[4] = '{1, 5'd12, 5'd1,  5'd12, 0, 0, 5'b00000};
        vecs[5] = '{1, 5'd5,  5'd5,  5'd5,  1, 1, 5'b11100};
        vecs[6] = '{0, 5'd0,  5'd0,  5'd0,  0, 1, 5'b00011};
        vecs[7] = '{1, 5'd3,  5'd3,  5'd0,  0, 1, 5'b00000};
        vecs[8] = '{0, 5'd0,  5'd0,  5'd0,  1, 0, 5'b11100};
        vecs[9] = '{1, 5'd31, 5'd31, 5'd2,  0, 0, 5'b00000};

        m_busy = 0; m_len = 0; m_st16 = 0; m_st4 = 0;
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        advance();
        cycle();
        check("reset_pc_write", int'(bus_a.pc_write), 0);
        check("reset_stall_cycles", int'(bus_a.stall_cycles), 0);

        for (int i = 0; i < 10; i++) begin
            do_reset(1);
            set_in(vecs[i].mr, vecs[i].ex_rt, vecs[i].rs, vecs[i].rt, vecs[i].br, vecs[i].ms, 0);
            sample();
            check($sformatf("vec%0d_ctl", i),
                  int'({bus_a.pc_write, bus_a.ifid_write, bus_a.ifid_flush, bus_a.ctrl_mux,
                        bus_a.md_go}), int'(vecs[i].exp_ctl));
            advance();
        end

        // Load-use: single bubble then free flow.
        do_reset(2);
        set_in(1, 5, 5, 0, 0, 0, 0);
        sample();
        check("lu_pc_write", int'(bus_a.pc_write), 0);
        advance();
        set_in(0, 5, 5, 0, 0, 0, 0);
        sample();
        check("lu_release_ctl", int'({bus_a.pc_write, bus_a.ifid_write, bus_a.ctrl_mux}), 7);
        check("lu_stall_cycles", int'(bus_a.stall_cycles), 1);
        advance();

        // Branch beats load-use and md_start; no stall counted.
        set_in(1, 5, 5, 0, 1, 1, 0);
        sample();
        check("br_ctl", int'({bus_a.pc_write, bus_a.ifid_flush, bus_a.ctrl_mux, bus_a.md_go}), 4'b1100);
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0);
        sample();
        check("br_no_busy", int'(bus_a.md_busy), 0);
        check("br_stall_cycles", int'(bus_a.stall_cycles), 1);
        advance();

        // Mul/div with done in the 4th busy cycle.
        do_reset(1);
        set_in(0, 0, 0, 0, 0, 1, 0);
        sample();
        check("md_issue", int'({bus_a.md_go, bus_a.ctrl_mux, bus_a.pc_write}), 3'b110);
        advance();
        for (int k = 1; k <= 4; k++) begin
            set_in(0, 0, 0, 0, 0, 0, (k == 4));
            sample();
            check($sformatf("md_busy%0d", k), int'(bus_a.md_busy), 1);
            check($sformatf("md_pc%0d", k), int'(bus_a.pc_write), (k == 4) ? 1 : 0);
            advance();
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        sample();
        check("md_back_run", int'(bus_a.md_busy), 0);
        check("md_stall_cycles", int'(bus_a.stall_cycles), 4);
        advance();

        // Timeout without done, then with done on the last allowed cycle.
        for (int rep = 0; rep < 2; rep++) begin
            do_reset(1);
            set_in(0, 0, 0, 0, 0, 1, 0);
            cycle();
            for (int k = 1; k <= MAXC; k++) begin
                set_in(0, 0, 0, 0, 0, 0, (rep == 1 && k == MAXC));
                sample();
                check($sformatf("to%0d_err%0d", rep, k), int'(bus_a.md_err),
                      (rep == 0 && k == MAXC) ? 1 : 0);
                if (k == MAXC) check($sformatf("to%0d_pc", rep), int'(bus_a.pc_write), 1);
                advance();
            end
            set_in(0, 0, 0, 0, 0, 0, 0);
            sample();
            check($sformatf("to%0d_run", rep), int'(bus_a.md_busy), 0);
            advance();
        end

        // Reset in the 3rd busy cycle aborts silently.
        do_reset(1);
        set_in(0, 0, 0, 0, 0, 1, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();
        reset = 1'b1;
        sample();
        check("rst_mid_ctl", int'({bus_a.md_err, bus_a.md_busy, bus_a.pc_write}), 0);
        advance();
        reset = 1'b0;
        sample();
        check("rst_mid_busy", int'(bus_a.md_busy), 0);
        check("rst_mid_stall", int'(bus_a.stall_cycles), 0);
        check("rst_mid_pc", int'(bus_a.pc_write), 1);
        advance();

        // Saturation of the narrow counter after 20 stalls.
        do_reset(1);
        set_in(1, 6, 1, 6, 0, 0, 0);
        repeat (20) cycle();
        set_in(0, 0, 0, 0, 0, 0, 0);
        sample();
        check("sat_cnt4", int'(bus_b.stall_cycles), 15);
        check("sat_cnt16", int'(bus_a.stall_cycles), 20);
        advance();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage 32-bit pipeline. It merges three hazard sources into one set of per-stage controls for the PC, the IF/ID register and the ID/EX control mux:
- load-use hazard;
- taken branch resolved in EX;
- multi-cycle multiply/divide unit handshake.

It owns the mul/div start/wait state machine, a wait timeout and a stall-cycle performance counter.

Parameters:
MD_MAX_CYCLES, 64, cycles allowed in MD_BUSY before timeout abort (legal range 2..65535)
CNT_W, 16, width of stall_cycles counter

Ports:
clk  in  1  pipeline clock, all state on rising edge
reset  in  1  synchronous, active-high
id_ex_memRead  in  1  instruction in EX is a load
id_ex_regRt  in  5  load destination register in EX
if_id_regRs  in  5  rs of instruction in ID
if_id_regRt  in  5  rt of instruction in ID
branch_taken  in  1  branch/jump in EX resolved taken this cycle
md_start  in  1  instruction in ID is mul/div
md_done  in  1  mul/div unit result valid (1-cycle pulse)
pc_write  out  1  1 = PC loads next value
ifid_write  out  1  1 = IF/ID register loads
ifid_flush  out  1  1 = IF/ID loaded with NOP this edge
ctrl_mux  out  1  1 = ID controls pass to ID/EX; 0 = bubble (all-zero controls)
md_go  out  1  1-cycle start pulse to mul/div unit
md_err  out  1  1-cycle pulse on timeout abort
md_busy  out  1  1 while in MD_BUSY
stall_cycles  out  CNT_W  count of stalled cycles

Behaviour:
- State machine: RUN, MD_BUSY. Registered state; outputs decoded combinationally from state and inputs (Mealy).
- Reset (reset=1 at an edge): state=RUN, wait counter=0, stall_cycles=0.
- While reset=1, regardless of state: pc_write=0, ifid_write=0, ctrl_mux=0, ifid_flush=0, md_go=0, md_err=0, md_busy=0.
- Reset has priority over everything, including mid-MD_BUSY. Reset aborts the wait with no md_err.
- Load-use hazard lu is defined as: id_ex_memRead=1 AND id_ex_regRt!=0 AND (id_ex_regRt==if_id_regRs OR id_ex_regRt==if_id_regRt). Register 0 never creates a hazard.
- RUN, evaluated in strict priority order:
  1. branch_taken=1: pc_write=1, ifid_write=1, ifid_flush=1, ctrl_mux=0. Any md_start or lu is ignored because the ID instruction is squashed. Stay RUN.
  2. lu=1: pc_write=0, ifid_write=0, ctrl_mux=0, no flush. md_go=0 even if md_start=1. Stay RUN, giving exactly one bubble per hazard.
  3. md_start=1: md_go=1, pc_write=0, ifid_write=0, ctrl_mux=1 (mul/div instruction advances to ID/EX). Next state MD_BUSY, wait counter cleared to 0.
  4. Otherwise: pc_write=1, ifid_write=1, ctrl_mux=1, all other outputs 0.
- MD_BUSY:
  - Outputs: md_busy=1, pc_write=0, ifid_write=0, ctrl_mux=0. branch_taken, lu and md_start are ignored (EX only holds bubbles).
  - Wait counter increments each cycle.
  - md_done=1: this cycle releases the pipe with pc_write=1, ifid_write=1, ctrl_mux=1. Next state RUN.
  - Timeout: if md_done=0 and the counter value equals MD_MAX_CYCLES-1 this cycle, md_err=1 for this cycle. Outputs are as for the md_done release. Next state RUN.
  - md_done together with the timeout cycle is treated as done, with no md_err.
  - md_done while in RUN is ignored.
- Latency: md_go is asserted in the same cycle md_start is accepted. The minimum MD_BUSY residency is 1 cycle, when md_done arrives in the first busy cycle.
- stall_cycles increments on every non-reset cycle with pc_write=0 (load-use, md issue cycle, MD_BUSY non-release cycles). It saturates at 2^CNT_W-1 and does not wrap.
- Flush cycles are not counted as stalls.

Test Plan:
- Load-use: reset 2 cycles, then memRead=1, regRt=5, ifid Rs=5 for 1 cycle → that cycle pc_write=0, ifid_write=0, ctrl_mux=0; next cycle (memRead=0) all 1; stall_cycles=1.
- Register-0 and no-hazard: memRead=1, regRt=0, Rs=0 → no stall. memRead=1, regRt=7, Rs=3, Rt=4 → no stall. memRead=0, regRt=Rs=9 → no stall.
- Branch priority: branch_taken=1 with lu true and md_start=1 → ifid_flush=1, ctrl_mux=0, pc_write=1, md_go=0; state stays RUN; stall_cycles unchanged.
- Mul/div handshake: md_start=1 → md_go=1 that cycle, ctrl_mux=1. md_done asserted 4 cycles later (in the 4th busy cycle) → md_busy=1 for 4 cycles with pc_write=0 on the first 3 and 1 on the 4th. stall_cycles=4, state back to RUN.
- Timeout: MD_MAX_CYCLES=8, md_done never asserted → md_err pulses in the 8th busy cycle with pc_write=1; RUN next. A repeat with md_done arriving in the 8th cycle → md_err=0.
- Reset mid-op and saturation: reset=1 in the 3rd busy cycle → next cycle RUN, stall_cycles=0, no md_err. CNT_W=4 with 20 stall cycles → stall_cycles holds 15.
